// File: rtl/hv_pos_crop_gen.sv
// Turns a raw DVI/HDMI receiver stream into a cropped, position-tagged pixel stream.
// Also measures line width, tracks frame lock and flags short lines inside the crop rows.
//
// state      | meaning
// WAIT_VSYNC | after reset; counters idle, no output until the first Vsync edge
// RUN        | counting pixels/lines; a Vsync edge restarts the frame
module hv_pos_crop_gen #(
  parameter int H_RES_PIX       = 640,
  parameter int V_RES_PIX       = 480,
  parameter int H_START         = 0,
  parameter int V_START         = 0,
  parameter int BITS_PER_PIXEL  = 24,
  parameter int HSYNC_POL       = 1,
  parameter int VSYNC_POL       = 1,
  parameter int LINE_READY_COMP = H_RES_PIX - 1,
  parameter int MW_BITS         = 13,
  localparam int HW = (H_RES_PIX > 2) ? $clog2(H_RES_PIX - 1) : 1,
  localparam int VW = (V_RES_PIX > 2) ? $clog2(V_RES_PIX - 1) : 1
) (
  input  logic                      vid_clk,
  input  logic                      reset_n,
  input  logic                      Hsync,
  input  logic                      Vsync,
  input  logic                      Active_pix,
  input  logic [BITS_PER_PIXEL-1:0] pixel_in,
  output logic [HW-1:0]             Hpos,
  output logic [VW-1:0]             Vpos,
  output logic                      VidEn,
  output logic [BITS_PER_PIXEL-1:0] pixel_out,
  output logic                      line_ready,
  output logic                      frame_ready,
  output logic [MW_BITS-1:0]        measured_width,
  output logic                      locked,
  output logic                      err_short_line
);

  localparam logic [31:0] X_LO   = H_START;
  localparam logic [31:0] X_END  = H_START + H_RES_PIX;
  localparam logic [31:0] Y_LO   = V_START;
  localparam logic [31:0] Y_END  = V_START + V_RES_PIX;
  localparam logic [31:0] H_RES  = H_RES_PIX;
  localparam logic [31:0] V_RES  = V_RES_PIX;
  localparam logic [31:0] LR_COL = LINE_READY_COMP;
  localparam logic [31:0] V_LAST = V_RES_PIX - 1;
  localparam int          AYW    = $clog2(V_START + V_RES_PIX + 1);

  typedef enum logic {WAIT_VSYNC, RUN} state_t;

  state_t               state;
  logic [1:0]           hs_sr, vs_sr;
  logic                 act_d;
  logic                 has_pix;
  logic                 short_seen;
  logic [MW_BITS-1:0]   ax;
  logic [AYW-1:0]       ay;

  logic                 hs_s, vs_s, hs_edge, vs_edge, line_end;
  logic [31:0]          ax32, ay32, hx, vy;
  logic                 col_in, row_in;

  assign hs_s     = (HSYNC_POL != 0) ? Hsync : ~Hsync;
  assign vs_s     = (VSYNC_POL != 0) ? Vsync : ~Vsync;
  assign hs_edge  = (hs_sr == 2'b01);
  assign vs_edge  = (vs_sr == 2'b01);
  assign line_end = hs_edge || (act_d && !Active_pix && has_pix);

  // Offsets wrap to large values below the window start, so one compare covers both bounds.
  assign ax32   = 32'(ax);
  assign ay32   = 32'(ay);
  assign hx     = ax32 - X_LO;
  assign vy     = ay32 - Y_LO;
  assign col_in = (hx < H_RES);
  assign row_in = (vy < V_RES);

  always_ff @(posedge vid_clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= WAIT_VSYNC;
      hs_sr          <= 2'b00;
      vs_sr          <= 2'b00;
      act_d          <= 1'b0;
      has_pix        <= 1'b0;
      short_seen     <= 1'b0;
      ax             <= '0;
      ay             <= '0;
      Hpos           <= '0;
      Vpos           <= '0;
      VidEn          <= 1'b0;
      pixel_out      <= '0;
      line_ready     <= 1'b0;
      frame_ready    <= 1'b0;
      measured_width <= '0;
      locked         <= 1'b0;
      err_short_line <= 1'b0;
    end else begin
      hs_sr          <= {hs_sr[0], hs_s};
      vs_sr          <= {vs_sr[0], vs_s};
      act_d          <= Active_pix;
      VidEn          <= 1'b0;
      line_ready     <= 1'b0;
      frame_ready    <= 1'b0;
      err_short_line <= 1'b0;

      if (vs_edge) begin
        // A frame evaluated while still waiting for sync is partial and never locks.
        locked     <= (state == RUN) && (ay32 >= Y_END) && !short_seen;
        state      <= RUN;
        ax         <= '0;
        ay         <= '0;
        has_pix    <= 1'b0;
        short_seen <= 1'b0;
      end else if (line_end) begin
        if (has_pix) begin
          measured_width <= ax;
          if (ay32 < Y_END)
            ay <= ay + AYW'(1);
          if (row_in && (ax32 < X_END)) begin
            err_short_line <= 1'b1;
            locked         <= 1'b0;
            short_seen     <= 1'b1;
          end
        end
        ax      <= '0;
        has_pix <= 1'b0;
      end else if ((state == RUN) && Active_pix) begin
        has_pix <= 1'b1;
        if (ax != '1)
          ax <= ax + MW_BITS'(1);
        if (row_in && col_in) begin
          VidEn       <= 1'b1;
          pixel_out   <= pixel_in;
          Hpos        <= hx[HW-1:0];
          Vpos        <= vy[VW-1:0];
          line_ready  <= (hx == LR_COL);
          frame_ready <= (hx == LR_COL) && (vy == V_LAST);
        end
      end
    end
  end

endmodule
